// File: rtl/pipe_fifo_gen2_pkg.sv
// rtl/pipe_fifo_gen2_pkg.sv - shared pipe defaults, log2 helper and watermark defaults
// Every pipe instance in the design draws its default geometry and thresholds from here.
package pipe_fifo_gen2_pkg;

    function automatic int pipe_log2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int PIPE_N_DEF         = 18;
    localparam int PIPE_DEPTH_DEF     = 16;
    localparam int PIPE_AW_DEF        = pipe_log2(PIPE_DEPTH_DEF);
    localparam int PIPE_AFULL_TH_DEF  = 12;
    localparam int PIPE_AEMPTY_TH_DEF = 2;

endpackage

// File: rtl/pipe_fifo_gen2_ptr_ctr.sv
// rtl/pipe_fifo_gen2_ptr_ctr.sv - AW-bit wrapping pointer with increment and synchronous clear
// DEPTH is a power of two, so natural overflow of the AW-bit register provides the wrap.
module pipe_ptr_ctr #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + AW'(1);
        end
    end

endmodule

// File: rtl/pipe_fifo_gen2.sv
// rtl/pipe_fifo_gen2.sv - req/ack FIFO with occupancy count, watermarks, flush and async reset
// Optional sticky overflow/underflow flags are built when PIPE_ERR_FLAGS_EN is defined.
module pipe_fifo_gen2
    import pipe_fifo_gen2_pkg::*;
#(
    parameter int N         = PIPE_N_DEF,
    parameter int DEPTH     = PIPE_DEPTH_DEF,
    parameter int AW        = PIPE_AW_DEF,
    parameter int AFULL_TH  = PIPE_AFULL_TH_DEF,
    parameter int AEMPTY_TH = PIPE_AEMPTY_TH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_flush,
    input  logic         pipe_write_req,
    output logic         pipe_write_ack,
    input  logic [N-1:0] pipe_write_data,
    input  logic         pipe_read_req,
    output logic         pipe_read_ack,
    output logic [N-1:0] pipe_read_data,
    output logic [AW:0]  pipe_count,
    output logic         pipe_almost_full,
    output logic         pipe_almost_empty
`ifdef PIPE_ERR_FLAGS_EN
    ,
    output logic         pipe_ovf,
    output logic         pipe_udf,
    input  logic         pipe_err_clr
`endif
);

    generate
        if ((AW < 1) || ((1 << AW) != DEPTH)) begin : g_bad_geometry
            $error("pipe_fifo_gen2: AW must equal log2(DEPTH) and DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          wr_fire;
    logic          rd_fire;

    // Full/empty come only from the count, never from pointer comparison.
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    assign wr_fire = pipe_write_req && !full  && !pipe_flush;
    assign rd_fire = pipe_read_req  && !empty && !pipe_flush;

    pipe_ptr_ctr #(.AW(AW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (pipe_flush),
        .inc (wr_fire),
        .ptr (wr_ptr)
    );

    pipe_ptr_ctr #(.AW(AW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (pipe_flush),
        .inc (rd_fire),
        .ptr (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= pipe_write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (pipe_flush) begin
            count <= '0;
        end else begin
            case ({wr_fire, rd_fire})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign pipe_write_ack    = !full;
    assign pipe_read_ack     = !empty;
    assign pipe_read_data    = mem[rd_ptr];
    assign pipe_count        = count;
    assign pipe_almost_full  = (count >= (AW+1)'(AFULL_TH));
    assign pipe_almost_empty = (count <= (AW+1)'(AEMPTY_TH));

`ifdef PIPE_ERR_FLAGS_EN
    // A new error on the same edge as a clear or flush must not be lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_ovf <= 1'b0;
            pipe_udf <= 1'b0;
        end else begin
            if (pipe_write_req && full) begin
                pipe_ovf <= 1'b1;
            end else if (pipe_err_clr || pipe_flush) begin
                pipe_ovf <= 1'b0;
            end
            if (pipe_read_req && empty) begin
                pipe_udf <= 1'b1;
            end else if (pipe_err_clr || pipe_flush) begin
                pipe_udf <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_fifo_gen2.sv
// tb/tb_pipe_fifo_gen2.sv - self-checking bench for pipe_fifo_gen2 against a queue model
// Covers PIPE_ERR_FLAGS_EN when the same macro is defined for the bench.
module tb_pipe_fifo_gen2;

    localparam int N     = 18;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pipe_flush = 1'b0;
    logic          pipe_write_req = 1'b0;
    logic          pipe_write_ack;
    logic [N-1:0]  pipe_write_data = '0;
    logic          pipe_read_req = 1'b0;
    logic          pipe_read_ack;
    logic [N-1:0]  pipe_read_data;
    logic [AW:0]   pipe_count;
    logic          pipe_almost_full;
    logic          pipe_almost_empty;
`ifdef PIPE_ERR_FLAGS_EN
    logic          pipe_ovf;
    logic          pipe_udf;
    logic          pipe_err_clr = 1'b0;
`endif

    pipe_fifo_gen2 #(.N(N), .DEPTH(DEPTH), .AW(AW), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .pipe_flush        (pipe_flush),
        .pipe_write_req    (pipe_write_req),
        .pipe_write_ack    (pipe_write_ack),
        .pipe_write_data   (pipe_write_data),
        .pipe_read_req     (pipe_read_req),
        .pipe_read_ack     (pipe_read_ack),
        .pipe_read_data    (pipe_read_data),
        .pipe_count        (pipe_count),
        .pipe_almost_full  (pipe_almost_full),
        .pipe_almost_empty (pipe_almost_empty)
`ifdef PIPE_ERR_FLAGS_EN
        ,
        .pipe_ovf          (pipe_ovf),
        .pipe_udf          (pipe_udf),
        .pipe_err_clr      (pipe_err_clr)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [N-1:0] q [$];
    logic         m_ovf = 1'b0;
    logic         m_udf = 1'b0;

    typedef struct {
        logic         wr;
        logic         rd;
        logic         fl;
        logic [N-1:0] d;
        int           cnt;
        logic         wack;
        logic         rack;
        logic [N-1:0] rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    // Model works on whole-FIFO rules: refused transfers do nothing, flush empties.
    task automatic model_step(input logic wr, input logic rd, input logic fl, input logic clr,
                              input logic [N-1:0] d);
        bit was_full;
        bit was_empty;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        if (wr && was_full) m_ovf = 1'b1;
        else if (clr || fl) m_ovf = 1'b0;
        if (rd && was_empty) m_udf = 1'b1;
        else if (clr || fl) m_udf = 1'b0;
        if (fl) begin
            q.delete();
        end else begin
            if (rd && !was_empty) void'(q.pop_front());
            if (wr && !was_full) q.push_back(d);
        end
    endtask

    task automatic drive(input logic wr, input logic rd, input logic fl, input logic clr,
                         input logic [N-1:0] d);
        pipe_write_req  = wr;
        pipe_read_req   = rd;
        pipe_flush      = fl;
        pipe_write_data = d;
`ifdef PIPE_ERR_FLAGS_EN
        pipe_err_clr    = clr;
`endif
        model_step(wr, rd, fl, clr, d);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":count"}, 32'(pipe_count), 32'(q.size()));
        chk({tag, ":write_ack"}, 32'(pipe_write_ack), 32'(q.size() != DEPTH));
        chk({tag, ":read_ack"}, 32'(pipe_read_ack), 32'(q.size() != 0));
        chk({tag, ":almost_full"}, 32'(pipe_almost_full), 32'(q.size() >= 12));
        chk({tag, ":almost_empty"}, 32'(pipe_almost_empty), 32'(q.size() <= 2));
        if (q.size() != 0) chk({tag, ":read_data"}, 32'(pipe_read_data), 32'(q[0]));
`ifdef PIPE_ERR_FLAGS_EN
        chk({tag, ":ovf"}, 32'(pipe_ovf), 32'(m_ovf));
        chk({tag, ":udf"}, 32'(pipe_udf), 32'(m_udf));
`endif
    endtask

    task automatic do_flush();
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check_model("flush");
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 18'h0000A, 1, 1'b1, 1'b1, 18'h0000A};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 18'h0000B, 1, 1'b1, 1'b1, 18'h0000B};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 18'h00000};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 18'h00000, 0, 1'b1, 1'b0, 18'h00000};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 18'h00111, 1, 1'b1, 1'b1, 18'h00111};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 18'h00222, 2, 1'b1, 1'b1, 18'h00111};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 18'h00333, 0, 1'b1, 1'b0, 18'h00000};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 18'h3FFFF, 1, 1'b1, 1'b1, 18'h3FFFF};

        // Reset state, observed while rst is still high.
        #3;
        chk("reset:count", 32'(pipe_count), 32'd0);
        chk("reset:write_ack", 32'(pipe_write_ack), 32'd1);
        chk("reset:read_ack", 32'(pipe_read_ack), 32'd0);
        chk("reset:almost_empty", 32'(pipe_almost_empty), 32'd1);
        chk("reset:almost_full", 32'(pipe_almost_full), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Hand-computed vectors from empty.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].fl, 1'b0, vecs[i].d);
            chk($sformatf("vec%0d:count", i), 32'(pipe_count), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d:write_ack", i), 32'(pipe_write_ack), 32'(vecs[i].wack));
            chk($sformatf("vec%0d:read_ack", i), 32'(pipe_read_ack), 32'(vecs[i].rack));
            if (vecs[i].rack) chk($sformatf("vec%0d:read_data", i), 32'(pipe_read_data), 32'(vecs[i].rdata));
        end
        do_flush();

        // Fill: 16 writes, then a dropped 17th.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 18'(i + 1));
            check_model("fill");
            chk("fill:almost_full_th", 32'(pipe_almost_full), 32'(i + 1 >= 12));
        end
        chk("fill:count16", 32'(pipe_count), 32'd16);
        chk("fill:write_ack0", 32'(pipe_write_ack), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 18'h00011);
        chk("fill:drop17", 32'(pipe_count), 32'd16);
        check_model("fill17");
`ifdef PIPE_ERR_FLAGS_EN
        chk("fill:ovf", 32'(pipe_ovf), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, '0);
        chk("errclr:ovf", 32'(pipe_ovf), 32'd0);
`endif

        // Drain: data in order.
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain:head", 32'(pipe_read_data), 32'(i + 1));
            drive(1'b0, 1'b1, 1'b0, 1'b0, '0);
            check_model("drain");
            chk("drain:almost_empty_th", 32'(pipe_almost_empty), 32'(DEPTH - 1 - i <= 2));
        end
        chk("drain:read_ack0", 32'(pipe_read_ack), 32'd0);

        // Wrap: steady occupancy of 5 for 40 cycles.
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 18'(18'h100 + i));
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0, 18'(18'h200 + i));
            check_model("wrap");
            chk("wrap:count5", 32'(pipe_count), 32'd5);
        end
        do_flush();

        // Full with both reqs: only the read fires.
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 18'(18'h300 + i));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 18'h3ABCD);
        chk("full_both:count15", 32'(pipe_count), 32'd15);
        chk("full_both:head", 32'(pipe_read_data), 32'h301);
        check_model("full_both");
        do_flush();

        // Empty with both reqs: only the write fires.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 18'h12345);
        chk("empty_both:count1", 32'(pipe_count), 32'd1);
        chk("empty_both:head", 32'(pipe_read_data), 32'h12345);
        check_model("empty_both");
        do_flush();

        // Flush at count 9 with write_req high.
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 18'(i));
        drive(1'b1, 1'b0, 1'b1, 1'b0, 18'h0BEEF);
        chk("flush9:count0", 32'(pipe_count), 32'd0);
        chk("flush9:read_ack0", 32'(pipe_read_ack), 32'd0);
        check_model("flush9");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic wr;
            logic rd;
            logic fl;
            logic clr;
            wr  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 70 : 35));
            rd  = ($urandom_range(0, 99) < ((i / 100) % 2 == 0 ? 35 : 70));
            fl  = ($urandom_range(0, 59) == 0);
            clr = ($urandom_range(0, 19) == 0);
            drive(wr, rd, fl, clr, 18'($urandom));
            check_model("rand");
        end

        // Asynchronous reset mid-stream, between clock edges.
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 18'(i + 7));
        drive(1'b1, 1'b1, 1'b0, 1'b0, 18'h00777);
        #2;
        rst = 1'b1;
        #1;
        chk("arst:read_ack0", 32'(pipe_read_ack), 32'd0);
        chk("arst:count0", 32'(pipe_count), 32'd0);
        chk("arst:write_ack1", 32'(pipe_write_ack), 32'd1);
        chk("arst:almost_empty1", 32'(pipe_almost_empty), 32'd1);
        chk("arst:almost_full0", 32'(pipe_almost_full), 32'd0);
`ifdef PIPE_ERR_FLAGS_EN
        chk("arst:ovf0", 32'(pipe_ovf), 32'd0);
        chk("arst:udf0", 32'(pipe_udf), 32'd0);
`endif
        #1;
        rst = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
        check_model("post_rst");
        drive(1'b1, 1'b0, 1'b0, 1'b0, 18'h2AAAA);
        check_model("post_rst_wr");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
